// File: rtl/alarm_clock_core.sv
// rtl/alarm_clock_core.sv - time-of-day core with multiple alarms, snooze/dismiss and tone output
module alarm_clock_core #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int NUM_ALARMS = 4,
    parameter int TONE_HZ    = 1000,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    parameter int MODE_24H   = 1,
    localparam int SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [1:0]            set_mode,
    input  logic                  btn_sel,
    input  logic                  btn_inc,
    input  logic [SEL_W-1:0]      alarm_sel,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [41:0]           hex_out,
    output logic                  led_alarm,
    output logic [1:0]            led_status,
    output logic                  speaker
);

    localparam int PRE_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int HALF_RAW  = CLK_HZ / (2 * TONE_HZ);
    localparam int HALF      = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int TONE_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int SNZ_W     = $clog2(SNZ_TICKS + 1);
    localparam int RING_W    = $clog2(RING_SEC + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RINGING = 2'b01,
        ST_SNOOZED = 2'b10
    } state_t;

    state_t state, state_next;

    logic set_time, set_alarm, run_mode;
    assign set_time  = (set_mode == 2'b01);
    assign set_alarm = (set_mode == 2'b10);
    assign run_mode  = ~set_time & ~set_alarm;

    // {dismiss, snooze, btn_inc, btn_sel}
    logic [3:0] in_cur, in_prev, in_rise;
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            in_cur  <= '0;
            in_prev <= '0;
        end else begin
            in_cur  <= {dismiss, snooze, btn_inc, btn_sel};
            in_prev <= in_cur;
        end
    end
    assign in_rise = in_cur & ~in_prev;

    logic sel_rise, inc_rise, snz_rise, dis_rise;
    assign sel_rise = in_rise[0];
    assign inc_rise = in_rise[1];
    assign snz_rise = in_rise[2];
    assign dis_rise = in_rise[3];

    logic [PRE_W-1:0] presc;
    logic             tick;
    assign tick = ~set_time && (presc == PRE_W'(CLK_HZ - 1));

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || set_time || tick) presc <= '0;
        else                                    presc <= presc + PRE_W'(1);
    end

    logic [4:0] hour;
    logic [5:0] min, sec;
    logic       field_min;
    logic       sec_wrap;
    logic [5:0] min_inc, tick_sec, tick_min;
    logic [4:0] hour_inc, tick_hour;

    assign sec_wrap  = (sec == 6'd59);
    assign min_inc   = (min == 6'd59) ? 6'd0 : min + 6'd1;
    assign hour_inc  = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    assign tick_sec  = sec_wrap ? 6'd0 : sec + 6'd1;
    assign tick_min  = sec_wrap ? min_inc : min;
    assign tick_hour = (sec_wrap && min == 6'd59) ? hour_inc : hour;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            hour <= '0;
            min  <= '0;
            sec  <= '0;
        end else if (set_time) begin
            sec <= '0;
            if (inc_rise) begin
                if (field_min) min  <= min_inc;
                else           hour <= hour_inc;
            end
        end else if (tick) begin
            sec  <= tick_sec;
            min  <= tick_min;
            hour <= tick_hour;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)  field_min <= 1'b0;
        else if (sel_rise)   field_min <= ~field_min;
    end

    logic [4:0] alarm_hour [NUM_ALARMS];
    logic [5:0] alarm_min  [NUM_ALARMS];

    always_ff @(posedge clk_clk) begin
        for (int k = 0; k < NUM_ALARMS; k++) begin
            if (!reset_reset_n) begin
                alarm_hour[k] <= '0;
                alarm_min[k]  <= '0;
            end else if (set_alarm && inc_rise && SEL_W'(k) == alarm_sel) begin
                if (field_min) alarm_min[k]  <= (alarm_min[k] == 6'd59) ? 6'd0 : alarm_min[k] + 6'd1;
                else           alarm_hour[k] <= (alarm_hour[k] == 5'd23) ? 5'd0 : alarm_hour[k] + 5'd1;
            end
        end
    end

    logic [4:0] sel_hour;
    logic [5:0] sel_min;
    logic       any_match, match;

    always_comb begin
        sel_hour  = '0;
        sel_min   = '0;
        any_match = 1'b0;
        for (int k = 0; k < NUM_ALARMS; k++) begin
            if (SEL_W'(k) == alarm_sel) begin
                sel_hour = alarm_hour[k];
                sel_min  = alarm_min[k];
            end
            // compare against the time this tick is about to produce
            if (alarm_en[k] && alarm_hour[k] == tick_hour && alarm_min[k] == tick_min)
                any_match = 1'b1;
        end
    end
    assign match = run_mode & tick & sec_wrap & any_match;

    logic [RING_W-1:0] ring_cnt, ring_next;
    logic [SNZ_W-1:0]  snz_cnt, snz_next;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state    <= ST_IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
        end else begin
            state    <= state_next;
            ring_cnt <= ring_next;
            snz_cnt  <= snz_next;
        end
    end

    always_comb begin
        state_next = state;
        ring_next  = ring_cnt;
        snz_next   = snz_cnt;
        if (!run_mode) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (match) begin
                        state_next = ST_RINGING;
                        ring_next  = RING_W'(RING_SEC);
                    end
                end
                ST_RINGING: begin
                    if (dis_rise) begin
                        state_next = ST_IDLE;
                    end else if (snz_rise) begin
                        state_next = ST_SNOOZED;
                        snz_next   = SNZ_W'(SNZ_TICKS);
                    end else if (tick) begin
                        ring_next = ring_cnt - RING_W'(1);
                        if (ring_cnt == RING_W'(1)) state_next = ST_IDLE;
                    end
                end
                ST_SNOOZED: begin
                    if (dis_rise) begin
                        state_next = ST_IDLE;
                    end else if (tick) begin
                        snz_next = snz_cnt - SNZ_W'(1);
                        if (snz_cnt == SNZ_W'(1)) begin
                            state_next = ST_RINGING;
                            ring_next  = RING_W'(RING_SEC);
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // tone follows the next state so it stops on the same edge the ring ends
    logic [TONE_W-1:0] tone_cnt;
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            tone_cnt  <= '0;
            speaker   <= 1'b0;
            led_alarm <= 1'b0;
        end else begin
            led_alarm <= (state_next == ST_RINGING);
            if (state_next == ST_RINGING) begin
                if (tone_cnt == TONE_W'(HALF - 1)) begin
                    tone_cnt <= '0;
                    speaker  <= ~speaker;
                end else begin
                    tone_cnt <= tone_cnt + TONE_W'(1);
                end
            end else begin
                tone_cnt <= '0;
                speaker  <= 1'b0;
            end
        end
    end
    assign led_status = state;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        t = '0;
        r = v;
        for (int i = 0; i < 5; i++) begin
            if (r >= 6'd10) begin
                r = r - 6'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    logic [4:0]  src_hour, disp_hour;
    logic [5:0]  src_min;
    logic [7:0]  bcd_h, bcd_m, bcd_s;
    logic [41:0] hex_next;

    always_comb begin
        src_hour = set_alarm ? sel_hour : hour;
        src_min  = set_alarm ? sel_min  : min;
        disp_hour = src_hour;
        if (MODE_24H == 0) begin
            if (src_hour == 5'd0)       disp_hour = 5'd12;
            else if (src_hour > 5'd12)  disp_hour = src_hour - 5'd12;
        end
        bcd_h = to_bcd({1'b0, disp_hour});
        bcd_m = to_bcd(src_min);
        bcd_s = to_bcd(sec);
        hex_next = {seg7(bcd_h[7:4]), seg7(bcd_h[3:0]),
                    seg7(bcd_m[7:4]), seg7(bcd_m[3:0]),
                    set_alarm ? 7'h7F : seg7(bcd_s[7:4]),
                    set_alarm ? 7'h7F : seg7(bcd_s[3:0])};
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) hex_out <= {6{7'h40}};
        else                hex_out <= hex_next;
    end

endmodule
